i2c_config_sequencer: RTL and testbench
=======================================

// Module: i2c_config_sequencer
// PURPOSE
//  Boot-time sequencer for the audio codec's I2C configuration. Walks an external byte table
//  and issues each entry as one WRITE transaction through i2c_controller, by driving its
//  enable/mode/periph_addr/transmit_byte ports and waiting on its ready output.
//  Sits between top-level reset/start logic and i2c_controller. Asserts done when the codec is configured.
// PARAMETERS
//  NUM_ENTRIES     8       number of table bytes to send (>=1)
//  IDX_W           3       width of the table index; 2**IDX_W >= NUM_ENTRIES
//  PERIPH_ADDR     7'h1A   7-bit codec address driven on i2c_periph_addr
//  ENABLE_HOLD     2       clk cycles i2c_enable is held high per transaction (>=1)
//  GAP_CYCLES      16      idle clk cycles between transactions (>=0)
//  TIMEOUT_CYCLES  4096    max cycles in any wait state before ERROR
// PORTS
//  clk                input   1      system clock, rising edge
//  reset              input   1      asynchronous, active-low reset
//  start              input   1      pulse/level; sampled in IDLE and DONE only
//  i2c_ready          input   1      ready from i2c_controller (high = idle/complete)
//  i2c_read_byte      input   8      byte_reg from i2c_controller
//  rom_data           input   8      table byte at rom_addr; combinational, valid the same cycle
//  rom_addr           output  IDX_W  current table index
//  i2c_enable         output  1      transaction request to i2c_controller
//  i2c_mode           output  1      0 = READ, 1 = WRITE
//  i2c_periph_addr    output  7      always PERIPH_ADDR
//  i2c_transmit_byte  output  8      registered copy of rom_data for the current entry
//  busy               output  1      high in every state except IDLE/DONE/ERROR
//  done               output  1      high in DONE
//  error              output  1      high in ERROR
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, rom_addr=0, i2c_enable=0, i2c_mode=1, i2c_transmit_byte=0,
//    busy=0, done=0, error=0, all counters=0. Reset mid-transaction aborts immediately;
//    i2c_enable drops in the same cycle.
//  - FSM: IDLE -start-> LOAD -> HOLD -> WAIT_BUSY -> WAIT_DONE -> GAP -> LOAD | DONE; any wait -> ERROR.
//    LOAD: latch rom_data into i2c_transmit_byte, set i2c_mode=1; next cycle enters HOLD.
//    HOLD: i2c_enable=1 for exactly ENABLE_HOLD cycles, then 0.
//    WAIT_BUSY: wait for i2c_ready=0 (controller accepted). If ready was already 0 during HOLD, skip to WAIT_DONE.
//    WAIT_DONE: wait for i2c_ready=1.
//    GAP: count GAP_CYCLES (0 = single pass-through cycle), then advance rom_addr.
//    If rom_addr == NUM_ENTRIES-1, go to DONE; otherwise rom_addr+1 and go to LOAD.
//  - Timeout: a single counter clears on entry to WAIT_BUSY/WAIT_DONE. On reaching TIMEOUT_CYCLES
//    the FSM goes to ERROR; rom_addr holds the failing index and i2c_enable=0.
//  - DONE and ERROR are sticky until start=1, which clears done/error, sets rom_addr=0 and enters LOAD.
//    start is ignored while busy.
//  - rom_addr never wraps: it saturates at NUM_ENTRIES-1.
//  - All outputs are registered. Latency from start to first i2c_enable rise is 2 cycles.
// CONFIGURATION
//  CFG_READBACK_EN defined: after WAIT_DONE of each write, a read-back is issued before GAP.
//    Sequence: RD_HOLD (i2c_mode=0, enable for ENABLE_HOLD) -> RD_WAIT_BUSY -> RD_WAIT_DONE -> CHECK.
//    Read-back waits use the same timeout rule.
//    CHECK compares i2c_read_byte with i2c_transmit_byte: mismatch -> ERROR, match -> GAP.
//  CFG_READBACK_EN undefined: the read-back states are not built and i2c_mode is constant 1.
// TESTING
//  1 reset=0 while busy at entry 3 -> all outputs at reset values in the same cycle; enable low.
//  2 NUM_ENTRIES=4, table {8'h1E,8'h00,8'h12,8'h01}, model acks after 20 cycles, start pulse ->
//    four transactions, i2c_transmit_byte matches the table in order, done=1, rom_addr=3.
//  3 model never drops ready, TIMEOUT_CYCLES=64 -> error=1 exactly 64 cycles after WAIT_BUSY entry,
//    rom_addr=0.
//  4 start held high during busy -> no restart; after done, start -> rom_addr=0, second full pass.
//  5 model drops ready during HOLD -> WAIT_BUSY is skipped, no timeout, sequence completes.
//  6 CFG_READBACK_EN, model returns 8'hFF for entry 2 -> error=1, rom_addr=2, mode=0 seen per entry.

Source files
------------

// File: rtl/i2c_config_sequencer_if.sv
// i2c_config_sequencer_if: the sequencer's two buses, bundled together.
//   - the configuration table (rom_addr out, rom_data back, combinational)
//   - the i2c_controller request/response signals
// The master modport is the sequencer's view. The slave modport is the view
// of the table plus controller side.
interface i2c_config_sequencer_if #(
    parameter int IDX_W = 3
);
    logic [IDX_W-1:0] rom_addr;
    logic [7:0]       rom_data;
    logic             i2c_enable;
    logic             i2c_mode;
    logic [6:0]       i2c_periph_addr;
    logic [7:0]       i2c_transmit_byte;
    logic             i2c_ready;
    logic [7:0]       i2c_read_byte;

    modport master (
        output rom_addr, i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte,
        input  rom_data, i2c_ready, i2c_read_byte
    );

    modport slave (
        input  rom_addr, i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte,
        output rom_data, i2c_ready, i2c_read_byte
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: boot-time sequencer for the audio codec configuration.
// It walks a byte table and sends each entry to the codec as one i2c_controller
// WRITE. It then waits for the controller to accept the request and to finish.
// Optional feature macro CFG_READBACK_EN: after each write, the sequencer reads
// the byte back and compares it with the byte it sent. A mismatch ends the walk
// in ERROR.
module i2c_config_sequencer #(
    parameter int         NUM_ENTRIES    = 8,
    parameter int         IDX_W          = 3,
    parameter logic [6:0] PERIPH_ADDR    = 7'h1A,
    parameter int         ENABLE_HOLD    = 2,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    i2c_config_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    // GAP lasts max(GAP_CYCLES,1) cycles. A single counter is shared by the
    // hold, timeout and gap phases, so it is sized for the largest of them.
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int MAX_A    = (TIMEOUT_CYCLES > ENABLE_HOLD) ? TIMEOUT_CYCLES : ENABLE_HOLD;
    localparam int CNT_MAX  = (MAX_A > GAP_LAST) ? MAX_A : GAP_LAST;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ENABLE_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_LAST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP,
`ifdef CFG_READBACK_EN
        ST_RD_HOLD,
        ST_RD_WAIT_BUSY,
        ST_RD_WAIT_DONE,
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accepted;    // the controller dropped ready while enable was held
    logic [IDX_W-1:0] rom_addr_q;
    logic             enable_q;
    logic [7:0]       tx_q;

    assign bus.rom_addr          = rom_addr_q;
    assign bus.i2c_enable        = enable_q;
    assign bus.i2c_transmit_byte = tx_q;
    assign bus.i2c_periph_addr   = PERIPH_ADDR;

`ifdef CFG_READBACK_EN
    logic mode_q;
    assign bus.i2c_mode = mode_q;
`else
    logic unused_read_byte;
    assign bus.i2c_mode      = 1'b1;
    assign unused_read_byte  = ^bus.i2c_read_byte;
`endif

    // Sequencer FSM. All outputs are registered here, alongside the state.
    // NOTE: the state and outputs use non-blocking assignments only. Every
    // decision therefore sees the values from before the clock edge, and all
    // registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            accepted   <= 1'b0;
            rom_addr_q <= '0;
            enable_q   <= 1'b0;
            tx_q       <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CFG_READBACK_EN
            mode_q     <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        rom_addr_q <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    tx_q     <= bus.rom_data;
                    enable_q <= 1'b1;
                    cnt      <= '0;
                    accepted <= 1'b0;
                    state    <= ST_HOLD;
`ifdef CFG_READBACK_EN
                    mode_q   <= 1'b1;
`endif
                end
                ST_HOLD: begin
                    accepted <= accepted | ~bus.i2c_ready;
                    if (cnt == HOLD_LAST) begin
                        enable_q <= 1'b0;
                        cnt      <= '0;
                        state    <= (accepted || !bus.i2c_ready) ? ST_WAIT_DONE : ST_WAIT_BUSY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!bus.i2c_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt == TO_LAST) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.i2c_ready) begin
                        cnt <= '0;
`ifdef CFG_READBACK_EN
                        mode_q   <= 1'b0;
                        enable_q <= 1'b1;
                        accepted <= 1'b0;
                        state    <= ST_RD_HOLD;
`else
                        state    <= ST_GAP;
`endif
                    end else if (cnt == TO_LAST) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef CFG_READBACK_EN
                ST_RD_HOLD: begin
                    accepted <= accepted | ~bus.i2c_ready;
                    if (cnt == HOLD_LAST) begin
                        enable_q <= 1'b0;
                        cnt      <= '0;
                        state    <= (accepted || !bus.i2c_ready) ? ST_RD_WAIT_DONE : ST_RD_WAIT_BUSY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RD_WAIT_BUSY: begin
                    if (!bus.i2c_ready) begin
                        cnt   <= '0;
                        state <= ST_RD_WAIT_DONE;
                    end else if (cnt == TO_LAST) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RD_WAIT_DONE: begin
                    if (bus.i2c_ready) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else if (cnt == TO_LAST) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (bus.i2c_read_byte != tx_q) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_GAP;
                    end
                end
`endif
                ST_GAP: begin
                    if (cnt == GAP_END) begin
                        cnt <= '0;
                        if (rom_addr_q == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            rom_addr_q <= rom_addr_q + IDX_W'(1);
                            state      <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    enable_q <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: randomized self-checking bench for i2c_config_sequencer.
// A behavioural i2c_controller answers each request:
//   - ready drops a_dly cycles after enable is seen;
//   - ready stays low for b_len cycles.
// The expected outputs are predicted every cycle from a closed-form per-entry
// schedule. The controller model also logs each accepted transaction, and the
// log is compared against the table.
module tb_i2c_config_sequencer;
    localparam int         N       = 4;
    localparam int         IW      = 2;
    localparam int         H       = 2;
    localparam int         GAP     = 3;
    localparam int         TMO     = 64;
    localparam logic [6:0] PADDR   = 7'h1A;
`ifdef CFG_READBACK_EN
    localparam bit         RB      = 1'b1;
`else
    localparam bit         RB      = 1'b0;
`endif

    typedef struct {
        bit         en, busy, done, err, mode;
        int         addr;
        logic [7:0] tx;
    } pred_t;

    typedef struct {
        logic       mode;
        int         addr;
        logic [7:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, error;
    i2c_config_sequencer_if #(.IDX_W(IW)) bus();

    i2c_config_sequencer #(
        .NUM_ENTRIES(N), .IDX_W(IW), .PERIPH_ADDR(PADDR),
        .ENABLE_HOLD(H), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [7:0] tbl [N];
    assign bus.rom_data = tbl[bus.rom_addr];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         edge_n   = 0;
    int         s_edge   = 0;
    int         a_dly    = 2;
    int         b_len    = 10;
    int         corrupt_idx = -1;
    bit         never_ack = 1'b0;
    bit         cmp_on    = 1'b0;
    logic [7:0] prev_tx   = 8'h00;
    bit         prev_mode = 1'b1;
    logic [7:0] last_written = 8'h00;
    int         first_en  = -1;
    txn_t       log_q [$];
    pred_t      p;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Schedule arithmetic: each entry takes a fixed number of cycles, set by
    // the controller delays.
    function automatic int m_val();
        return (H > a_dly + b_len) ? H : a_dly + b_len;
    endfunction

    function automatic int per_entry();
        return (RB ? 4 + 2 * m_val() : 2 + m_val()) + ((GAP > 0) ? GAP : 1);
    endfunction

    function automatic int pass_len();
        if (RB && corrupt_idx >= 0) return corrupt_idx * per_entry() + 4 + 2 * m_val();
        return N * per_entry();
    endfunction

    function automatic pred_t predict(input int e);
        pred_t q;
        int m, per, k, r;
        bit err_end;
        m = m_val();
        per = per_entry();
        err_end = RB && (corrupt_idx >= 0);
        if (e >= pass_len()) begin
            q.en = 0; q.busy = 0; q.done = !err_end; q.err = err_end;
            q.addr = err_end ? corrupt_idx : N - 1;
            q.tx = tbl[q.addr];
            q.mode = RB ? 1'b0 : 1'b1;
        end else begin
            k = e / per;
            r = e % per;
            q.busy = 1; q.done = 0; q.err = 0; q.addr = k;
            q.en = (r >= 1 && r <= H) || (RB && r >= 2 + m && r <= 1 + m + H);
            if (r >= 1) q.tx = tbl[k];
            else if (k > 0) q.tx = tbl[k - 1];
            else q.tx = prev_tx;
            if (!RB) q.mode = 1'b1;
            else if (r == 0) q.mode = (k > 0) ? 1'b0 : prev_mode;
            else q.mode = (r < 2 + m) ? 1'b1 : 1'b0;
        end
        return q;
    endfunction

    // Per-cycle compare of all DUT outputs against the schedule prediction.
    always @(negedge clk) begin
        if (cmp_on) begin
            p = predict(edge_n - s_edge);
            check("enable", bus.i2c_enable, p.en);
            check("busy", busy, p.busy);
            check("done", done, p.done);
            check("error", error, p.err);
            check("rom_addr", bus.rom_addr, p.addr);
            check("tx_byte", bus.i2c_transmit_byte, p.tx);
            check("mode", bus.i2c_mode, p.mode);
            check("periph_addr", bus.i2c_periph_addr, PADDR);
            if (bus.i2c_enable && first_en < 0) first_en = edge_n - s_edge;
        end
    end

    // Behavioural i2c_controller and codec register.
    initial begin
        bus.i2c_ready = 1'b1;
        bus.i2c_read_byte = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.i2c_enable && !never_ack) begin
                log_q.push_back('{mode: bus.i2c_mode, addr: int'(bus.rom_addr), data: bus.i2c_transmit_byte});
                repeat (a_dly) begin @(posedge clk); #1; end
                bus.i2c_ready = 1'b0;
                if (bus.i2c_mode) last_written = bus.i2c_transmit_byte;
                else bus.i2c_read_byte = (int'(bus.rom_addr) == corrupt_idx) ? 8'hFF : last_written;
                repeat (b_len) begin @(posedge clk); #1; end
                bus.i2c_ready = 1'b1;
                while (bus.i2c_enable) begin @(posedge clk); #1; end
            end
        end
    end

    task automatic run_pass(input int a, input int b, input bit hold_start);
        int t_end, n_ent, k;
        bit fin;
        a_dly = a;
        b_len = b;
        log_q.delete();
        first_en = -1;
        t_end = pass_len();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        s_edge = edge_n;
        cmp_on = 1'b1;
        if (!hold_start) start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < t_end + 100 && !fin; i++) begin
            @(posedge clk); #1;
            if (hold_start && (edge_n - s_edge) >= t_end - 3) start = 1'b0;
            if (done || error) fin = 1'b1;
        end
        start = 1'b0;
        check("pass_finished", fin, 1);
        check("finish_offset", edge_n - s_edge, t_end);
        @(negedge clk); #1;
        cmp_on = 1'b0;
        n_ent = (RB && corrupt_idx >= 0) ? corrupt_idx + 1 : N;
        check("log_len", log_q.size(), n_ent * (RB ? 2 : 1));
        for (int i = 0; i < log_q.size() && i < n_ent * (RB ? 2 : 1); i++) begin
            k = RB ? i / 2 : i;
            check("log_addr", log_q[i].addr, k);
            check("log_data", log_q[i].data, tbl[k]);
            check("log_mode", log_q[i].mode, (RB && (i % 2 == 1)) ? 1'b0 : 1'b1);
        end
        prev_tx = tbl[n_ent - 1];
        prev_mode = RB ? 1'b0 : 1'b1;
    endtask

    task automatic random_table();
        for (int i = 0; i < N; i++) tbl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"}, bus.rom_addr, 0);
        check({tag, "_enable"}, bus.i2c_enable, 0);
        check({tag, "_mode"}, bus.i2c_mode, 1);
        check({tag, "_tx"}, bus.i2c_transmit_byte, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_periph"}, bus.i2c_periph_addr, PADDR);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_e, cnt_e;
        bit seen;
        logic [7:0] lit [N];
        lit = '{8'h1E, 8'h00, 8'h12, 8'h01};
        reset = 1'b0;
        start = 1'b0;
        tbl = lit;
        #3;
        check_reset_values("in_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("after_reset");

        // Table walk with 20-cycle controller transactions. Literals pin the model.
        check("model_pass_len", pass_len() + 0 * a_dly, pass_len());
        a_dly = 3; b_len = 20;
        check("model_literal_len", pass_len(), RB ? 212 : 112);
        run_pass(3, 20, 1'b0);
        check("start_to_enable", first_en + 1, 2);
        for (int i = 0; i < N; i++) check("table_order", log_q[i * (RB ? 2 : 1)].data, lit[i]);
        check("done_addr", bus.rom_addr, 3);
        check("done_flag", done, 1);

        // The controller accepts during HOLD, so WAIT_BUSY is skipped. The
        // second pass also finishes ready within HOLD.
        run_pass(0, 7, 1'b0);
        run_pass(0, 1, 1'b0);

        // Randomized tables and controller latencies.
        for (int t = 0; t < 6; t++) begin
            random_table();
            run_pass($urandom_range(0, 6), $urandom_range(1, 30), 1'b0);
        end

        // start is held through the pass and must be ignored; then a fresh pass.
        random_table();
        run_pass($urandom_range(0, 4), $urandom_range(1, 12), 1'b1);
        run_pass($urandom_range(0, 4), $urandom_range(1, 12), 1'b0);

        // The controller never accepts: timeout exactly TMO cycles after WAIT_BUSY entry.
        never_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        fall_e = -1;
        for (int i = 0; i < 20 && fall_e < 0; i++) begin
            if (bus.i2c_enable) seen = 1'b1;
            else if (seen) fall_e = edge_n;
            if (fall_e < 0) begin @(posedge clk); #1; end
        end
        check("timeout_enable_seen", seen, 1);
        cnt_e = -1;
        for (int i = 0; i < 200 && cnt_e < 0; i++) begin
            @(posedge clk); #1;
            if (error) cnt_e = edge_n - fall_e;
        end
        check("timeout_cycles", cnt_e, 64);
        check("timeout_addr", bus.rom_addr, 0);
        check("timeout_enable", bus.i2c_enable, 0);
        check("timeout_busy", busy, 0);
        check("timeout_done", done, 0);
        never_ack = 1'b0;
        prev_tx = tbl[0];
        prev_mode = 1'b1;
        repeat (5) @(posedge clk);
        random_table();
        run_pass($urandom_range(0, 6), $urandom_range(1, 20), 1'b0);
        check("recover_error_cleared", error, 0);

`ifdef CFG_READBACK_EN
        // Read-back of entry 2 returns 8'hFF, so the walk stops in ERROR at index 2.
        corrupt_idx = 2;
        random_table();
        tbl[2] = 8'h5A;
        run_pass(2, 9, 1'b0);
        check("rb_error", error, 1);
        check("rb_err_addr", bus.rom_addr, 2);
        corrupt_idx = -1;
`endif

        // Reset while busy at entry 3: every output returns to reset immediately.
        random_table();
        a_dly = 2; b_len = 10;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (int'(bus.rom_addr) == 3 && bus.i2c_enable) seen = 1'b1;
        end
        check("reached_entry3", seen, 1);
        check("busy_before_reset", busy, 1);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_reset_values("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
